// File: rtl/ps2_key_tracker_pkg.sv
// Shared PS/2 set-2 scan codes, key indices, decoder states and the key lookup helper
// used by the direction-key tracker.
package ps2_key_tracker_pkg;

  localparam logic [7:0] CODE_E0         = 8'hE0;
  localparam logic [7:0] CODE_F0         = 8'hF0;
  localparam logic [7:0] CODE_UP         = 8'h1D;
  localparam logic [7:0] CODE_DOWN       = 8'h1B;
  localparam logic [7:0] CODE_LEFT       = 8'h1C;
  localparam logic [7:0] CODE_RIGHT      = 8'h23;
  localparam logic [7:0] CODE_EXT_UP     = 8'h75;
  localparam logic [7:0] CODE_EXT_DOWN   = 8'h72;
  localparam logic [7:0] CODE_EXT_LEFT   = 8'h6B;
  localparam logic [7:0] CODE_EXT_RIGHT  = 8'h74;

  localparam logic [1:0] KEY_UP    = 2'd0;
  localparam logic [1:0] KEY_DOWN  = 2'd1;
  localparam logic [1:0] KEY_LEFT  = 2'd2;
  localparam logic [1:0] KEY_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK
  } decodeState_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } keyHit_t;

  // Extended and plain tables are disjoint on purpose: E0 1D must not map to up.
  function automatic keyHit_t decodeKey(input logic [7:0] code, input logic ext);
    keyHit_t r;
    r.hit = 1'b1;
    r.idx = KEY_UP;
    if (ext) begin
      case (code)
        CODE_EXT_UP:    r.idx = KEY_UP;
        CODE_EXT_DOWN:  r.idx = KEY_DOWN;
        CODE_EXT_LEFT:  r.idx = KEY_LEFT;
        CODE_EXT_RIGHT: r.idx = KEY_RIGHT;
        default:        r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        CODE_UP:    r.idx = KEY_UP;
        CODE_DOWN:  r.idx = KEY_DOWN;
        CODE_LEFT:  r.idx = KEY_LEFT;
        CODE_RIGHT: r.idx = KEY_RIGHT;
        default:    r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_axis_stepper.sv
// One sprite axis: on each tick moves pos by STEP toward inc or dec, clamped to 0..MAX.
module axis_stepper #(
  parameter int STEP = 4,
  parameter int MAX  = 589,
  parameter int INIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       dec,
  input  logic       inc,
  output logic [9:0] pos
);

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] MAX_W  = 11'(MAX);
  localparam logic [9:0]  MAX_P  = 10'(MAX);
  localparam logic [9:0]  INIT_P = 10'(INIT);

  logic [10:0] posW;
  logic [9:0]  posNext;

  assign posW = {1'b0, pos};

  // Comparisons run in 11 bits so neither the subtract nor the add can wrap.
  always_comb begin
    // NOTE: default assigned first so no path leaves posNext unassigned (no latch).
    posNext = pos;
    if (tick && dec && !inc) begin
      posNext = (posW < STEP_W) ? '0 : 10'(posW - STEP_W);
    end else if (tick && inc && !dec) begin
      posNext = (posW > MAX_W - STEP_W) ? MAX_P : 10'(posW + STEP_W);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) pos <= INIT_P;
    else       pos <= posNext;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes the PS/2 set-2 stream into held/press/release state for four direction keys
// and steps per-frame clamped sprite offsets from the held keys.
module ps2_key_tracker
  import ps2_key_tracker_pkg::*;
#(
  parameter int STEP    = 4,
  parameter int X_MAX   = 589,
  parameter int Y_MAX   = 429,
  parameter int X_INIT  = 0,
  parameter int Y_INIT  = 0,
  parameter int TIMEOUT = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scanValid,
  input  logic [7:0] scanData,
  input  logic       frameTick,
  output logic [3:0] keyHeld,
  output logic [3:0] keyPress,
  output logic [3:0] keyRelease,
  output logic [9:0] xOffset,
  output logic [9:0] yOffset,
  output logic [7:0] lastCode
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  decodeState_t  state, stateNext;
  logic [TW-1:0] timer;
  logic          frameTickQ;
  logic          frameEdge;
  keyHit_t       hit;
  logic          makeEn, breakEn, codeDone;

  assign frameEdge = frameTick & ~frameTickQ;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= stateNext;
  end

  // A byte always wins over an expiring timer; repeated prefixes keep the pending state.
  always_comb begin
    stateNext = state;
    makeEn    = 1'b0;
    breakEn   = 1'b0;
    codeDone  = 1'b0;
    hit       = decodeKey(scanData, (state == S_EXT) || (state == S_EXTBRK));
    if (scanValid) begin
      if (scanData == CODE_E0) begin
        if (state == S_IDLE) stateNext = S_EXT;
      end else if (scanData == CODE_F0) begin
        if (state == S_IDLE)     stateNext = S_BRK;
        else if (state == S_EXT) stateNext = S_EXTBRK;
      end else begin
        codeDone  = 1'b1;
        stateNext = S_IDLE;
        makeEn    = hit.hit && ((state == S_IDLE) || (state == S_EXT));
        breakEn   = hit.hit && ((state == S_BRK)  || (state == S_EXTBRK));
      end
    end else if (state != S_IDLE && timer >= TIMER_LAST) begin
      stateNext = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || scanValid || stateNext == S_IDLE) timer <= '0;
    else                                           timer <= timer + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keyHeld    <= '0;
      keyPress   <= '0;
      keyRelease <= '0;
      lastCode   <= '0;
      frameTickQ <= 1'b0;
    end else begin
      keyPress   <= '0;
      keyRelease <= '0;
      frameTickQ <= frameTick;
      if (makeEn) begin
        keyHeld[hit.idx]  <= 1'b1;
        keyPress[hit.idx] <= ~keyHeld[hit.idx];
      end
      if (breakEn) begin
        keyHeld[hit.idx]    <= 1'b0;
        keyRelease[hit.idx] <= keyHeld[hit.idx];
      end
      if (codeDone) lastCode <= scanData;
    end
  end

  // Steppers see keyHeld before this edge's key update, so motion lags a make by one frame.
  axis_stepper #(.STEP(STEP), .MAX(X_MAX), .INIT(X_INIT)) xStep (
    .clk   (clk),
    .reset (reset),
    .tick  (frameEdge),
    .dec   (keyHeld[KEY_LEFT]),
    .inc   (keyHeld[KEY_RIGHT]),
    .pos   (xOffset)
  );

  axis_stepper #(.STEP(STEP), .MAX(Y_MAX), .INIT(Y_INIT)) yStep (
    .clk   (clk),
    .reset (reset),
    .tick  (frameEdge),
    .dec   (keyHeld[KEY_UP]),
    .inc   (keyHeld[KEY_DOWN]),
    .pos   (yOffset)
  );

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: vector table, hand-written corner sequences and random
// traffic, all compared each cycle against a prefix/timestamp reference model.
module tb_ps2_key_tracker;

  localparam int TIMEOUT = 40;
  localparam int STEP    = 4;
  localparam int X_MAX   = 589;
  localparam int Y_MAX   = 429;

  logic       clk = 1'b0;
  logic       reset;
  logic       scanValid;
  logic [7:0] scanData;
  logic       frameTick;
  logic [3:0] keyHeld, keyPress, keyRelease;
  logic [9:0] xOffset, yOffset;
  logic [7:0] lastCode;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] mHeld, mPress, mRelease;
  logic [7:0] mLast;
  logic       mExt, mBrk, mPrevFt;
  int         mX, mY, cyc, mPrefixCyc;

  ps2_key_tracker #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .scanValid  (scanValid),
    .scanData   (scanData),
    .frameTick  (frameTick),
    .keyHeld    (keyHeld),
    .keyPress   (keyPress),
    .keyRelease (keyRelease),
    .xOffset    (xOffset),
    .yOffset    (yOffset),
    .lastCode   (lastCode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Key index for a code in the plain or extended table, -1 when not a direction key.
  function automatic int lookup(input logic [7:0] code, input logic ext);
    logic [7:0] plainCodes[4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    logic [7:0] extCodes[4]   = '{8'h75, 8'h72, 8'h6B, 8'h74};
    for (int k = 0; k < 4; k++) begin
      if (!ext && code == plainCodes[k]) return k;
      if (ext && code == extCodes[k]) return k;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mHeld = '0; mPress = '0; mRelease = '0; mLast = '0;
    mExt = 1'b0; mBrk = 1'b0; mPrevFt = 1'b0;
    mX = 0; mY = 0; mPrefixCyc = 0;
  endtask

  task automatic compareModel();
    check("keyHeld", 32'(keyHeld), 32'(mHeld));
    check("keyPress", 32'(keyPress), 32'(mPress));
    check("keyRelease", 32'(keyRelease), 32'(mRelease));
    check("xOffset", 32'(xOffset), 32'(mX));
    check("yOffset", 32'(yOffset), 32'(mY));
    check("lastCode", 32'(lastCode), 32'(mLast));
  endtask

  // One clock with the given inputs; the model predicts the post-edge outputs.
  task automatic tick(input logic sv, input logic [7:0] sd, input logic ft);
    logic [3:0] newHeld;
    int idx;
    scanValid = sv; scanData = sd; frameTick = ft;
    mPress = '0; mRelease = '0;
    newHeld = mHeld;
    if (ft && !mPrevFt) begin
      if (mHeld[0] && !mHeld[1]) mY = (mY < STEP) ? 0 : mY - STEP;
      else if (mHeld[1] && !mHeld[0]) mY = (mY + STEP > Y_MAX) ? Y_MAX : mY + STEP;
      if (mHeld[2] && !mHeld[3]) mX = (mX < STEP) ? 0 : mX - STEP;
      else if (mHeld[3] && !mHeld[2]) mX = (mX + STEP > X_MAX) ? X_MAX : mX + STEP;
    end
    mPrevFt = ft;
    if ((mExt || mBrk) && (cyc - mPrefixCyc) > TIMEOUT) begin
      mExt = 1'b0; mBrk = 1'b0;
    end
    if (sv) begin
      if (sd == 8'hE0) begin
        if (!mBrk) mExt = 1'b1;
        mPrefixCyc = cyc;
      end else if (sd == 8'hF0) begin
        mBrk = 1'b1;
        mPrefixCyc = cyc;
      end else begin
        idx = lookup(sd, mExt);
        if (idx >= 0) begin
          if (mBrk) begin
            mRelease[idx] = mHeld[idx];
            newHeld[idx] = 1'b0;
          end else begin
            mPress[idx] = ~mHeld[idx];
            newHeld[idx] = 1'b1;
          end
        end
        mLast = sd;
        mExt = 1'b0; mBrk = 1'b0;
      end
    end
    mHeld = newHeld;
    @(posedge clk);
    #1;
    scanValid = 1'b0;
    compareModel();
    cyc++;
  endtask

  task automatic doReset(input logic sv, input logic [7:0] sd, input logic ft);
    reset = 1'b1; scanValid = sv; scanData = sd; frameTick = ft;
    @(posedge clk);
    #1;
    modelReset();
    check("rst_keyHeld", 32'(keyHeld), 32'h0);
    check("rst_keyPress", 32'(keyPress), 32'h0);
    check("rst_keyRelease", 32'(keyRelease), 32'h0);
    check("rst_xOffset", 32'(xOffset), 32'h0);
    check("rst_yOffset", 32'(yOffset), 32'h0);
    check("rst_lastCode", 32'(lastCode), 32'h0);
    reset = 1'b0; scanValid = 1'b0; frameTick = 1'b0;
    cyc++;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) tick(1'b0, 8'h00, 1'b1);
      repeat (3) tick(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic [3:0] held;
    logic [3:0] press;
    logic [3:0] rel;
    logic [7:0] last;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int pressCount;
    int ftLeft;
    logic ftLevel;
    logic [7:0] pool[10] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] sd;

    reset = 1'b0; scanValid = 1'b0; scanData = '0; frameTick = 1'b0;
    cyc = 0;
    modelReset();

    vecs[0]  = '{1'b1, 8'hE0, 4'h0, 4'h0, 4'h0, 8'h00};
    vecs[1]  = '{1'b1, 8'h6B, 4'h4, 4'h4, 4'h0, 8'h6B};
    vecs[2]  = '{1'b0, 8'h00, 4'h4, 4'h0, 4'h0, 8'h6B};
    vecs[3]  = '{1'b1, 8'hE0, 4'h4, 4'h0, 4'h0, 8'h6B};
    vecs[4]  = '{1'b1, 8'hF0, 4'h4, 4'h0, 4'h0, 8'h6B};
    vecs[5]  = '{1'b1, 8'h6B, 4'h0, 4'h0, 4'h4, 8'h6B};
    vecs[6]  = '{1'b1, 8'h6B, 4'h0, 4'h0, 4'h0, 8'h6B};
    vecs[7]  = '{1'b1, 8'h1D, 4'h1, 4'h1, 4'h0, 8'h1D};
    vecs[8]  = '{1'b1, 8'h1D, 4'h1, 4'h0, 4'h0, 8'h1D};
    vecs[9]  = '{1'b1, 8'hE0, 4'h1, 4'h0, 4'h0, 8'h1D};
    vecs[10] = '{1'b1, 8'h1D, 4'h1, 4'h0, 4'h0, 8'h1D};
    vecs[11] = '{1'b1, 8'hF0, 4'h1, 4'h0, 4'h0, 8'h1D};
    vecs[12] = '{1'b1, 8'h1D, 4'h0, 4'h0, 4'h1, 8'h1D};
    vecs[13] = '{1'b1, 8'hF0, 4'h0, 4'h0, 4'h0, 8'h1D};
    vecs[14] = '{1'b1, 8'h1B, 4'h0, 4'h0, 4'h0, 8'h1B};
    vecs[15] = '{1'b1, 8'hE0, 4'h0, 4'h0, 4'h0, 8'h1B};
    vecs[16] = '{1'b1, 8'hE0, 4'h0, 4'h0, 4'h0, 8'h1B};
    vecs[17] = '{1'b1, 8'h74, 4'h8, 4'h8, 4'h0, 8'h74};

    // Vector table: extended make/break, typematic, E0 1D, stray break, repeated E0
    doReset(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 18; i++) begin
      tick(vecs[i].sv, vecs[i].sd, 1'b0);
      check($sformatf("vec%0d_held", i), 32'(keyHeld), 32'(vecs[i].held));
      check($sformatf("vec%0d_press", i), 32'(keyPress), 32'(vecs[i].press));
      check($sformatf("vec%0d_rel", i), 32'(keyRelease), 32'(vecs[i].rel));
      check($sformatf("vec%0d_last", i), 32'(lastCode), 32'(vecs[i].last));
    end

    // Up held at top edge stays clamped at 0
    doReset(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h1D, 1'b0);
    check("up_press", 32'(keyPress), 32'h1);
    frames(3);
    check("up_held", 32'(keyHeld), 32'h1);
    check("up_clamp_y", 32'(yOffset), 32'd0);

    // Down for 5 edges, then break; further edges leave y alone
    doReset(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h1B, 1'b0);
    frames(5);
    check("down_y20", 32'(yOffset), 32'd20);
    tick(1'b1, 8'hF0, 1'b0);
    tick(1'b1, 8'h1B, 1'b0);
    check("down_release", 32'(keyRelease), 32'h2);
    frames(1);
    check("down_y_after_rel", 32'(yOffset), 32'd20);

    // Typematic right: one press pulse, then saturate X
    doReset(1'b0, 8'h00, 1'b0);
    pressCount = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 8'h23, 1'b0);
      pressCount += int'(keyPress[3]);
      tick(1'b0, 8'h00, 1'b0);
      pressCount += int'(keyPress[3]);
    end
    check("typematic_presses", 32'(pressCount), 32'd1);
    check("typematic_held", 32'(keyHeld[3]), 32'h1);
    frames(200);
    check("x_saturated", 32'(xOffset), 32'd589);

    // Pending break expires before the code arrives, so 1C is a make
    doReset(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hF0, 1'b0);
    idle(TIMEOUT + 1);
    tick(1'b1, 8'h1C, 1'b0);
    check("timeout_make_held", 32'(keyHeld), 32'h4);
    check("timeout_make_press", 32'(keyPress), 32'h4);
    // Within the window the same bytes form a break
    tick(1'b1, 8'hF0, 1'b0);
    idle(5);
    tick(1'b1, 8'h1C, 1'b0);
    check("window_break_held", 32'(keyHeld), 32'h0);
    check("window_break_rel", 32'(keyRelease), 32'h4);

    // Make coinciding with a frame edge moves only on the following edge
    doReset(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h1B, 1'b1);
    check("same_edge_y", 32'(yOffset), 32'd0);
    idle(2);
    frames(2);
    check("next_edge_y", 32'(yOffset), 32'd8);
    // Up and down together: no motion
    tick(1'b1, 8'h1D, 1'b0);
    frames(2);
    check("both_held_y", 32'(yOffset), 32'd8);
    // Reset mid-frame with keys held and a byte arriving
    tick(1'b1, 8'h23, 1'b1);
    doReset(1'b1, 8'h1C, 1'b1);

    // Random traffic against the model
    ftLevel = 1'b0;
    ftLeft = 3;
    for (int i = 0; i < 4000; i++) begin
      if (ftLeft == 0) begin
        ftLevel = ~ftLevel;
        ftLeft = int'($urandom_range(1, 6));
      end
      ftLeft--;
      if ($urandom_range(0, 199) == 0) begin
        repeat (TIMEOUT + 3) tick(1'b0, 8'h00, ftLevel);
      end
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 11) < 10) sd = pool[$urandom_range(0, 9)];
        else sd = 8'($urandom);
        tick(1'b1, sd, ftLevel);
      end else begin
        tick(1'b0, 8'h00, ftLevel);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
